// File: rtl/spi_flash_rd.sv
// Wishbone read-only responder that fetches one 32-bit word per request over SPI flash (mode 0).
// Define FAST_READ_EN to use FAST READ (0x0B) with 8 dummy clocks instead of plain READ (0x03).
module spi_flash_rd #(
  parameter int CLK_DIV   = 1,
  parameter int ADDR_BITS = 24
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic        wb_cyc,
  input  logic [31:0] wb_adr,
  output logic        wb_ack,
  output logic [31:0] wb_rdt,
  output logic        busy,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  // state | meaning
  // IDLE  | waiting for wb_cyc, CS high
  // CMD   | shifting out the 8-bit command
  // ADDR  | shifting out the 24-bit flash address
  // DUMMY | 8 dummy clocks (FAST_READ_EN builds only)
  // DATA  | shifting in 32 data bits
  // ACK   | one-cycle wb_ack with the assembled word, CS high
  // GAP   | one-cycle CS deselect time before accepting again

  generate
    if (ADDR_BITS != 24) begin : g_bad_addr_bits
      $error("spi_flash_rd: only ADDR_BITS=24 is supported");
    end
    if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
      $error("spi_flash_rd: CLK_DIV must be in 1..255");
    end
  endgenerate

`ifdef FAST_READ_EN
  localparam logic [7:0] CMD_BYTE = 8'h0B;
  localparam logic [6:0] LAST_BIT = 7'd71;
`else
  localparam logic [7:0] CMD_BYTE = 8'h03;
  localparam logic [6:0] LAST_BIT = 7'd63;
`endif
  localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
  // Two lead cycles between CS falling and the first SCK half-period give MOSI setup margin.
  localparam logic [1:0] LEAD_CYCLES = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
`ifdef FAST_READ_EN
    S_DUMMY,
`endif
    S_DATA,
    S_ACK,
    S_GAP
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  lead_q, lead_d;
  logic [7:0]  div_q, div_d;
  logic [6:0]  bit_q, bit_d;
  logic        sck_q, sck_d;
  logic        cs_n_q, cs_n_d;
  logic        busy_q, busy_d;
  logic        ack_q, ack_d;
  logic [31:0] rdt_q, rdt_d;
  logic [31:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;

  logic unused_adr_hi;
  assign unused_adr_hi = &{1'b0, wb_adr[31:24]};

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= S_IDLE;
      lead_q  <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      sck_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      rdt_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
    end else begin
      state_q <= state_d;
      lead_q  <= lead_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sck_q   <= sck_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      rdt_q   <= rdt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lead_d  = lead_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sck_d   = sck_q;
    cs_n_d  = cs_n_q;
    busy_d  = busy_q;
    ack_d   = 1'b0;
    rdt_d   = '0;
    tx_d    = tx_q;
    rx_d    = rx_q;

    case (state_q)
      S_IDLE: begin
        if (wb_cyc) begin
          state_d = S_CMD;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          lead_d  = LEAD_CYCLES;
          div_d   = DIV_RELOAD;
          bit_d   = '0;
          sck_d   = 1'b0;
          tx_d    = {CMD_BYTE, wb_adr[23:0]};
          rx_d    = '0;
        end
      end

`ifdef FAST_READ_EN
      S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
`else
      S_CMD, S_ADDR, S_DATA: begin
`endif
        if (!wb_cyc) begin
          state_d = S_GAP;
          cs_n_d  = 1'b1;
          sck_d   = 1'b0;
          bit_d   = '0;
          tx_d    = '0;
          rx_d    = '0;
        end else if (lead_q != 2'd0) begin
          lead_d = lead_q - 2'd1;
        end else if (div_q != 8'd0) begin
          div_d = div_q - 8'd1;
        end else begin
          div_d = DIV_RELOAD;
          if (!sck_q) begin
            sck_d = 1'b1;
            if (state_q == S_DATA) rx_d = {rx_q[30:0], spi_miso};
          end else begin
            sck_d = 1'b0;
            tx_d  = {tx_q[30:0], 1'b0};
            bit_d = bit_q + 7'd1;
            if (bit_q == LAST_BIT) begin
              state_d = S_ACK;
              ack_d   = 1'b1;
              // first byte received lands in the low byte of the word
              rdt_d   = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
              cs_n_d  = 1'b1;
              bit_d   = '0;
              rx_d    = '0;
            end else if (bit_q == 7'd7) begin
              state_d = S_ADDR;
            end else if (bit_q == 7'd31) begin
`ifdef FAST_READ_EN
              state_d = S_DUMMY;
            end else if (bit_q == 7'd39) begin
`endif
              state_d = S_DATA;
            end
          end
        end
      end

      S_ACK: state_d = S_GAP;

      S_GAP: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        cs_n_d  = 1'b1;
        sck_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign wb_ack   = ack_q;
  assign wb_rdt   = rdt_q;
  assign busy     = busy_q;
  assign spi_cs_n = cs_n_q;
  assign spi_sck  = sck_q;
  assign spi_mosi = tx_q[31];

endmodule

// File: tb/tb_spi_flash_rd.sv
// Bench for spi_flash_rd: two instances (CLK_DIV=1 and 3), each with a behavioural SPI flash.
// Expected words and MOSI headers are queued when a request is driven and checked at wb_ack.
module tb_spi_flash_rd;

`ifdef FAST_READ_EN
  localparam logic [7:0] EXP_CMD = 8'h0B;
  localparam int DS = 40;
  localparam int NB = 144;
`else
  localparam logic [7:0] EXP_CMD = 8'h03;
  localparam int DS = 32;
  localparam int NB = 128;
`endif

  logic wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  logic        wb_rst_n;
  logic        cyc    [2];
  logic [31:0] adr    [2];
  logic        ack    [2];
  logic [31:0] rdt    [2];
  logic        busy   [2];
  logic        cs_n   [2];
  logic        sck    [2];
  logic        mosi   [2];
  logic [6:0]  bitn_a [2];
  logic [31:0] cap_a  [2];
  int          per_a  [2];

  int cyc_cnt = 0;
  always @(posedge wb_clk) cyc_cnt <= cyc_cnt + 1;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q [$];
  logic [31:0] mo_q  [$];

  function automatic logic [7:0] fb(input logic [23:0] a);
    case (a)
      24'h100000: fb = 8'h13;
      24'h100001: fb = 8'h05;
      24'h100002: fb = 8'h00;
      24'h100003: fb = 8'h00;
      24'h123454: fb = 8'hDE;
      24'h123455: fb = 8'hAD;
      24'h123456: fb = 8'hBE;
      24'h123457: fb = 8'hEF;
      default:    fb = (a[7:0] * 8'd7) ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input logic [23:0] a);
    exp_word = {fb(a + 24'd3), fb(a + 24'd2), fb(a + 24'd1), fb(a)};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic        miso_l = 1'b1;
    logic        sck_p  = 1'b0;
    logic [6:0]  bitn   = '0;
    logic [31:0] msh    = '0;
    logic [31:0] cap    = '0;
    logic [31:0] strm   = '0;
    logic [31:0] msh_n;
    int          last_rise = 0;
    int          per       = 0;

    spi_flash_rd #(.CLK_DIV(g == 0 ? 1 : 3), .ADDR_BITS(24)) u_dut (
      .wb_clk  (wb_clk),
      .wb_rst_n(wb_rst_n),
      .wb_cyc  (cyc[g]),
      .wb_adr  (adr[g]),
      .wb_ack  (ack[g]),
      .wb_rdt  (rdt[g]),
      .busy    (busy[g]),
      .spi_cs_n(cs_n[g]),
      .spi_sck (sck[g]),
      .spi_mosi(mosi[g]),
      .spi_miso(miso_l)
    );

    assign msh_n     = {msh[30:0], mosi[g]};
    assign bitn_a[g] = bitn;
    assign cap_a[g]  = cap;
    assign per_a[g]  = per;

    // flash model: shifts data out after SCK falls, captures MOSI while SCK is high
    always @(negedge wb_clk) begin
      sck_p <= sck[g];
      if (cs_n[g]) begin
        bitn   <= '0;
        miso_l <= 1'b1;
      end else if (sck[g] && !sck_p) begin
        bitn      <= bitn + 7'd1;
        per       <= cyc_cnt - last_rise;
        last_rise <= cyc_cnt;
        if (bitn < 7'd32) msh <= msh_n;
        if (bitn == 7'd31) begin
          cap  <= msh_n;
          strm <= {fb(msh_n[23:0]), fb(msh_n[23:0] + 24'd1),
                   fb(msh_n[23:0] + 24'd2), fb(msh_n[23:0] + 24'd3)};
        end
      end else if (!sck[g] && sck_p) begin
        if (int'(bitn) >= DS && int'(bitn) < DS + 32)
          miso_l <= strm[5'(DS + 31 - int'(bitn))];
        else
          miso_l <= 1'b1;
      end
    end
  end

  // Drives one read on instance i from a negedge and checks it through ack and the gap.
  task automatic do_read(input int i, input logic [31:0] a, input bit keep,
                         output int t_acc, output int t_ack);
    int n;
    int lat;
    logic [31:0] e_rdt;
    logic [31:0] e_mo;
    lat = 2 + NB * ((i == 0) ? 1 : 3);
    t_acc = -1;
    t_ack = -1;
    cyc[i] = 1'b1;
    adr[i] = a;
    exp_q.push_back(exp_word(a[23:0]));
    mo_q.push_back({EXP_CMD, a[23:0]});
    n = 0;
    while (cs_n[i] !== 1'b0 && n < 20) begin
      @(negedge wb_clk);
      n++;
    end
    n_tests++;
    if (cs_n[i] !== 1'b0) begin
      n_fail++;
      $display("FAIL accept_timeout adr=%h: cs_n=%b required 0", a, cs_n[i]);
      void'(exp_q.pop_front());
      void'(mo_q.pop_front());
      cyc[i] = 1'b0;
      return;
    end
    t_acc = cyc_cnt;
    n_tests++;
    if (busy[i] !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_at_accept adr=%h: got %b required 1", a, busy[i]);
    end
    n = 0;
    while (ack[i] !== 1'b1 && n < lat + 50) begin
      @(negedge wb_clk);
      n++;
    end
    n_tests++;
    if (ack[i] !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_timeout adr=%h: no ack within %0d cycles", a, lat + 50);
      void'(exp_q.pop_front());
      void'(mo_q.pop_front());
      cyc[i] = 1'b0;
      return;
    end
    t_ack = cyc_cnt;
    e_rdt = exp_q.pop_front();
    e_mo  = mo_q.pop_front();
    n_tests++;
    if (t_ack - t_acc !== lat) begin
      n_fail++;
      $display("FAIL ack_latency adr=%h: got %0d required %0d", a, t_ack - t_acc, lat);
    end
    n_tests++;
    if (rdt[i] !== e_rdt) begin
      n_fail++;
      $display("FAIL rdt adr=%h: got %h required %h", a, rdt[i], e_rdt);
    end
    n_tests++;
    if (cap_a[i] !== e_mo) begin
      n_fail++;
      $display("FAIL mosi_header adr=%h: got %h required %h", a, cap_a[i], e_mo);
    end
    if (!keep) cyc[i] = 1'b0;
    @(negedge wb_clk);
    n_tests++;
    if (ack[i] !== 1'b0 || rdt[i] !== 32'h0 || busy[i] !== 1'b1 || cs_n[i] !== 1'b1) begin
      n_fail++;
      $display("FAIL gap_cycle adr=%h: ack=%b rdt=%h busy=%b cs_n=%b required 0,0,1,1",
               a, ack[i], rdt[i], busy[i], cs_n[i]);
    end
    if (!keep) begin
      @(negedge wb_clk);
      n_tests++;
      if (busy[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_fall adr=%h: got %b required 0", a, busy[i]);
      end
    end
  endtask

  task automatic test_reset();
    wb_rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc[i] = 1'b0;
      adr[i] = 32'h0;
    end
    repeat (3) @(negedge wb_clk);
    wb_rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge wb_clk);
      for (int i = 0; i < 2; i++) begin
        n_tests++;
        if (cs_n[i] !== 1'b1 || sck[i] !== 1'b0 || ack[i] !== 1'b0 || busy[i] !== 1'b0 ||
            rdt[i] !== 32'h0 || mosi[i] !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_%0d cycle %0d: cs_n=%b sck=%b ack=%b busy=%b rdt=%h mosi=%b required 1,0,0,0,0,0",
                   i, k, cs_n[i], sck[i], ack[i], busy[i], rdt[i], mosi[i]);
        end
      end
    end
  endtask

  task automatic test_basic();
    int ta, tk;
    do_read(0, 32'h0010_0000, 1'b0, ta, tk);
    n_tests++;
    if (per_a[0] !== 2) begin
      n_fail++;
      $display("FAIL sck_period_div1: got %0d required 2", per_a[0]);
    end
  endtask

  task automatic test_clkdiv();
    int ta, tk;
    do_read(1, 32'h0012_3454, 1'b0, ta, tk);
    n_tests++;
    if (per_a[1] !== 6) begin
      n_fail++;
      $display("FAIL sck_period_div3: got %0d required 6", per_a[1]);
    end
  endtask

  task automatic test_back_to_back();
    int ta1, tk1, ta2, tk2;
    do_read(0, 32'h0000_0000, 1'b1, ta1, tk1);
    do_read(0, 32'h0000_0004, 1'b0, ta2, tk2);
    n_tests++;
    if (ta2 - tk1 < 2) begin
      n_fail++;
      $display("FAIL b2b_spacing: got %0d cycles after ack, required at least 2", ta2 - tk1);
    end
  endtask

  task automatic test_abort();
    int n;
    int ta, tk;
    bit bad;
    cyc[0] = 1'b1;
    adr[0] = 32'h0000_0040;
    n = 0;
    while (bitn_a[0] < 7'd20 && n < 200) begin
      @(negedge wb_clk);
      n++;
    end
    cyc[0] = 1'b0;
    @(negedge wb_clk);
    n_tests++;
    if (cs_n[0] !== 1'b1 || sck[0] !== 1'b0 || ack[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_edge: cs_n=%b sck=%b ack=%b required 1,0,0", cs_n[0], sck[0], ack[0]);
    end
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge wb_clk);
      if (ack[0] !== 1'b0 || rdt[0] !== 32'h0) bad = 1'b1;
    end
    n_tests++;
    if (bad || busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_quiet: ack/rdt seen=%b busy=%b required 0,0", bad, busy[0]);
    end
    do_read(0, 32'h0000_0008, 1'b0, ta, tk);
  endtask

  task automatic test_reset_mid();
    int n;
    int ta, tk;
    cyc[0] = 1'b1;
    adr[0] = 32'h0000_0010;
    n = 0;
    while (int'(bitn_a[0]) < DS + 8 && n < 400) begin
      @(negedge wb_clk);
      n++;
    end
    wb_rst_n = 1'b0;
    #1;
    n_tests++;
    if (cs_n[0] !== 1'b1 || sck[0] !== 1'b0 || busy[0] !== 1'b0 || ack[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: cs_n=%b sck=%b busy=%b ack=%b required 1,0,0,0",
               cs_n[0], sck[0], busy[0], ack[0]);
    end
    cyc[0] = 1'b0;
    repeat (2) @(negedge wb_clk);
    wb_rst_n = 1'b1;
    @(negedge wb_clk);
    do_read(0, 32'h0000_000C, 1'b0, ta, tk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_clkdiv();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    repeat (2) @(negedge wb_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
